mpu_transpose_stream: RTL and testbench

//  Streaming N x N matrix transpose unit for the MPU datapath. It is the parametrised, sequential

---
 rtl/mpu_pkg.sv | 25 ++
 rtl/mpu_matrix_bank.sv | 91 +++++++++
 rtl/mpu_transpose_stream.sv | 115 +++++++++++
 tb/tb_mpu_transpose_stream.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpu_pkg.sv
// Purpose: shared types and helpers for the MPU streaming transpose datapath.
// Latency: none (types, constants and a width helper only).
// Backpressure: none (no logic of its own).
// Contents: element width, mode_e, bank_state_e, cnt_w() counter-width helper.
package mpu_pkg;

  localparam int ELEM_W = 8;

  typedef enum logic {
    MODE_PASS      = 1'b0,
    MODE_TRANSPOSE = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

  // Row counters need at least one bit, even for a 1x1 matrix.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mpu_matrix_bank.sv
// Purpose: one N x N bank of the ping-pong buffer: row write port, fill state, per-matrix mode.
// Latency: a written row is visible on the read port the cycle after its write.
// Backpressure: none of its own; the parent only writes while the bank is not FULL.
// Ports: clk, rst_n (sync, active-low); wr_en/wr_idx/wr_row/wr_mode row write (mode taken on row 0);
//        rd_idx selects the result row; rd_done empties the bank; full = bank holds a whole matrix;
//        rd_row = stored row rd_idx (PASS) or stored column rd_idx (TRANSPOSE).
module mpu_matrix_bank
  import mpu_pkg::*;
#(
  parameter int N = 5,
  parameter int W = ELEM_W,
  localparam int CW = cnt_w(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [CW-1:0]   wr_idx,
  input  logic [N*W-1:0]  wr_row,
  input  logic            wr_mode,
  input  logic [CW-1:0]   rd_idx,
  input  logic            rd_done,
  output logic            full,
  output logic [N*W-1:0]  rd_row
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  bank_state_e            state_q, state_d;
  mode_e                  mode_q, mode_d;
  logic [N-1:0][N*W-1:0]  mem_q, mem_d;
  logic                   wr_first;
  logic                   wr_last;

  assign wr_first = (wr_idx == '0);
  assign wr_last  = (wr_idx == LAST);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BANK_EMPTY;
      mode_q  <= MODE_PASS;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  // Element storage carries no reset; the bank state alone says whether it is meaningful.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Next-state logic. With N = 1 the first row is also the last, so EMPTY goes straight to FULL.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BANK_EMPTY:   if (wr_en) state_d = wr_last ? BANK_FULL : BANK_FILLING;
      BANK_FILLING: if (wr_en && wr_last) state_d = BANK_FULL;
      BANK_FULL:    if (rd_done) state_d = BANK_EMPTY;
      default:      state_d = BANK_EMPTY;
    endcase
  end

  // Storage and mode updates
  always_comb begin
    mode_d = mode_q;
    mem_d  = mem_q;
    if (wr_en) begin
      if (wr_first) mode_d = mode_e'(wr_mode);
      for (int r = 0; r < N; r++) begin
        if (wr_idx == CW'(r)) mem_d[r] = wr_row;
      end
    end
  end

  // Outputs: status and the selected row or column
  always_comb begin
    full   = (state_q == BANK_FULL);
    rd_row = '0;
    for (int r = 0; r < N; r++) begin
      if (rd_idx == CW'(r)) begin
        if (mode_q == MODE_TRANSPOSE) begin
          for (int c = 0; c < N; c++) rd_row[c*W +: W] = mem_q[c][r*W +: W];
        end else begin
          rd_row = mem_q[r];
        end
      end
    end
  end

endmodule

// File: rtl/mpu_transpose_stream.sv
// Purpose: streaming N x N transpose / pass-through, one row per handshake in and out, ping-pong banks.
// Latency: last input row accepted at edge t -> out_valid high in the cycle after t.
// Backpressure: in_ready drops only when the write bank is still FULL; outputs hold while out_ready is low.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/in_row/in_mode (mode sampled on row 0);
//        out_valid/out_ready/out_row/out_last (last = row N-1 of the matrix). Element c at [c*W +: W].
module mpu_transpose_stream
  import mpu_pkg::*;
#(
  parameter int N = 5,
  parameter int W = ELEM_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*W-1:0]  in_row,
  input  logic            in_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*W-1:0]  out_row,
  output logic            out_last
);

  localparam int            CW   = cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic                   wr_sel_q, wr_sel_d;
  logic                   rd_sel_q, rd_sel_d;
  logic [CW-1:0]          wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]          rd_cnt_q, rd_cnt_d;

  logic [1:0]             bank_full;
  logic [1:0][N*W-1:0]    bank_row;
  logic [1:0]             bank_wr_en;
  logic [1:0]             bank_rd_done;
  logic                   in_xfer;
  logic                   out_xfer;
  logic                   rd_last;

  // Handshake and output mux: everything here depends on registered state only,
  // except the transfer strobes that feed back into next-state logic.
  always_comb begin
    in_ready  = !bank_full[wr_sel_q];
    out_valid = bank_full[rd_sel_q];
    rd_last   = (rd_cnt_q == LAST);
    out_last  = out_valid && rd_last;
    out_row   = out_valid ? bank_row[rd_sel_q] : '0;

    in_xfer  = in_valid && in_ready;
    out_xfer = out_valid && out_ready;

    bank_wr_en   = '0;
    bank_rd_done = '0;
    bank_wr_en[wr_sel_q]   = in_xfer;
    bank_rd_done[rd_sel_q] = out_xfer && rd_last;
  end

  // Row counters; each wraps at N-1 and hands over to the other bank.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    wr_sel_d = wr_sel_q;
    if (in_xfer) begin
      if (wr_cnt_q == LAST) begin
        wr_cnt_d = '0;
        wr_sel_d = !wr_sel_q;
      end else begin
        wr_cnt_d = wr_cnt_q + CW'(1);
      end
    end

    rd_cnt_d = rd_cnt_q;
    rd_sel_d = rd_sel_q;
    if (out_xfer) begin
      if (rd_last) begin
        rd_cnt_d = '0;
        rd_sel_d = !rd_sel_q;
      end else begin
        rd_cnt_d = rd_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    mpu_matrix_bank #(
      .N (N),
      .W (W)
    ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (bank_wr_en[b]),
      .wr_idx  (wr_cnt_q),
      .wr_row  (in_row),
      .wr_mode (in_mode),
      .rd_idx  (rd_cnt_q),
      .rd_done (bank_rd_done[b]),
      .full    (bank_full[b]),
      .rd_row  (bank_row[b])
    );
  end

endmodule

// File: tb/tb_mpu_transpose_stream.sv
// Purpose: self-checking bench for mpu_transpose_stream at N=5/W=8, N=1/W=8 and N=8/W=16.
// Latency: n/a. Backpressure: driven by the bench (directed stalls and random out_ready).
// Reference: accepted rows are collected per matrix and the result rows are built by plain arithmetic.
module tb_mpu_transpose_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Instance A: N=5, W=8
  logic        a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready, a_out_last;
  logic [39:0] a_in_row, a_out_row;
  // Instance B: N=1, W=8
  logic        b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_out_last;
  logic [7:0]  b_in_row, b_out_row;
  // Instance C: N=8, W=16
  logic         c_in_valid, c_in_ready, c_in_mode, c_out_valid, c_out_ready, c_out_last;
  logic [127:0] c_in_row, c_out_row;

  mpu_transpose_stream #(.N(5), .W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_row(a_in_row), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_row(a_out_row), .out_last(a_out_last)
  );

  mpu_transpose_stream #(.N(1), .W(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_row(b_in_row), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_row(b_out_row), .out_last(b_out_last)
  );

  mpu_transpose_stream #(.N(8), .W(16)) u_dut_c (
    .clk(clk), .rst_n(rst_n),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_row(c_in_row), .in_mode(c_in_mode),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_row(c_out_row), .out_last(c_out_last)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state, one slot per instance
  int           acc [3][64];
  int           acc_cnt [3];
  logic         acc_mode [3];
  logic [127:0] exp_mem [3][64];
  logic         exp_last_mem [3][64];
  int           exp_wr [3];
  int           exp_rd [3];
  int           out_cnt [3];
  logic         acc_flag [3];
  logic         prev_v [3];
  logic         prev_r [3];
  logic [127:0] prev_row [3];
  logic         prev_last [3];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      acc_cnt[i]  = 0;
      exp_wr[i]   = 0;
      exp_rd[i]   = 0;
      acc_flag[i] = 1'b0;
      prev_v[i]   = 1'b0;
      prev_r[i]   = 1'b0;
    end
  endtask

  // One instance's view of one cycle: protocol checks, output scoreboard, input capture.
  task automatic mon(input int i, input int n, input int w,
                     input logic iv, input logic ir, input logic [127:0] irow, input logic im,
                     input logic ov, input logic ordy, input logic [127:0] orow, input logic ol);
    logic [127:0] v;
    int e;
    if (prev_v[i] && !prev_r[i]) begin
      chk("hold_valid", 128'(ov), 128'(1));
      chk("hold_row", orow, prev_row[i]);
      chk("hold_last", 128'(ol), 128'(prev_last[i]));
    end
    if (!ov) chk("idle_row_zero", orow, 128'(0));
    prev_v[i]    = ov;
    prev_r[i]    = ordy;
    prev_row[i]  = orow;
    prev_last[i] = ol;

    if (ov && ordy) begin
      out_cnt[i]++;
      chk("out_expected", 128'(exp_wr[i] > exp_rd[i]), 128'(1));
      if (exp_wr[i] > exp_rd[i]) begin
        chk("out_row", orow, exp_mem[i][exp_rd[i] % 64]);
        chk("out_last", 128'(ol), 128'(exp_last_mem[i][exp_rd[i] % 64]));
        exp_rd[i]++;
      end
    end

    acc_flag[i] = iv && ir;
    if (iv && ir) begin
      if (acc_cnt[i] == 0) acc_mode[i] = im;
      for (int c = 0; c < n; c++)
        acc[i][acc_cnt[i]*n + c] = int'((irow >> (c*w)) & ((128'(1) << w) - 128'(1)));
      acc_cnt[i]++;
      if (acc_cnt[i] == n) begin
        for (int r = 0; r < n; r++) begin
          v = '0;
          for (int c = 0; c < n; c++) begin
            e = acc_mode[i] ? acc[i][c*n + r] : acc[i][r*n + c];
            v = v | (128'(e) << (c*w));
          end
          exp_mem[i][exp_wr[i] % 64]      = v;
          exp_last_mem[i][exp_wr[i] % 64] = (r == n - 1);
          exp_wr[i]++;
        end
        acc_cnt[i] = 0;
      end
    end
  endtask

  // Sample at the falling edge, then move to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    if (rst_n) begin
      mon(0, 5, 8, a_in_valid, a_in_ready, 128'(a_in_row), a_in_mode,
          a_out_valid, a_out_ready, 128'(a_out_row), a_out_last);
      mon(1, 1, 8, b_in_valid, b_in_ready, 128'(b_in_row), b_in_mode,
          b_out_valid, b_out_ready, 128'(b_out_row), b_out_last);
      mon(2, 8, 16, c_in_valid, c_in_ready, c_in_row, c_in_mode,
          c_out_valid, c_out_ready, c_out_row, c_out_last);
    end else begin
      model_reset();
    end
    @(posedge clk);
    #1;
  endtask

  // 5x5 row r of a matrix whose element (r,c) is base+10r+c, or of its transpose.
  function automatic logic [39:0] mk5(input int base, input int r, input bit tr);
    logic [39:0] v;
    v = '0;
    for (int c = 0; c < 5; c++) v[c*8 +: 8] = 8'(tr ? base + 10*c + r : base + 10*r + c);
    return v;
  endfunction

  // Fill one matrix into an empty instance A and drain it with out_ready high.
  task automatic run_matrix5(input string tag, input int base, input bit mode);
    a_out_ready = 1'b1;
    for (int r = 0; r < 5; r++) begin
      a_in_valid = 1'b1;
      a_in_row   = mk5(base, r, 1'b0);
      a_in_mode  = (r == 0) ? mode : !mode;
      chk({tag, "_no_early_valid"}, 128'(a_out_valid), 128'(0));
      tick();
    end
    a_in_valid = 1'b0;
    a_in_mode  = 1'b0;
    for (int r = 0; r < 5; r++) begin
      chk({tag, "_valid"}, 128'(a_out_valid), 128'(1));
      chk({tag, "_row"}, 128'(a_out_row), 128'(mk5(base, r, mode)));
      chk({tag, "_last"}, 128'(a_out_last), 128'(r == 4));
      tick();
    end
    chk({tag, "_done"}, 128'(a_out_valid), 128'(0));
  endtask

  int k;

  initial begin
    for (int i = 0; i < 3; i++) out_cnt[i] = 0;
    model_reset();
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_row = '0; a_in_mode = 1'b0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_row = '0; b_in_mode = 1'b0; b_out_ready = 1'b0;
    c_in_valid = 1'b0; c_in_row = '0; c_in_mode = 1'b0; c_out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    chk("rst_in_ready", 128'(a_in_ready), 128'(1));
    chk("rst_out_valid", 128'(a_out_valid), 128'(0));
    chk("rst_out_last", 128'(a_out_last), 128'(0));
    chk("rst_out_row", 128'(a_out_row), 128'(0));
    chk("rst_b_in_ready", 128'(b_in_ready), 128'(1));
    chk("rst_c_in_ready", 128'(c_in_ready), 128'(1));

    // Transpose, then pass-through (mode flips on later rows must be ignored)
    run_matrix5("t1", 0, 1'b1);
    run_matrix5("t2", 0, 1'b0);

    // Two matrices back to back with no gaps
    a_out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a_in_valid = (i < 10);
      a_in_row   = mk5((i < 5) ? 20 : 60, i % 5, 1'b0);
      a_in_mode  = (i == 0) || (i >= 6);
      if (i < 10) chk("t3_in_ready", 128'(a_in_ready), 128'(1));
      chk("t3_out_valid", 128'(a_out_valid), 128'(i >= 5 && i < 15));
      tick();
    end
    a_in_valid = 1'b0;

    // Output stalled: two matrices fill, then input stalls with valid held
    a_out_ready = 1'b0;
    k = 0;
    for (int i = 0; i < 12; i++) begin
      a_in_valid = 1'b1;
      a_in_row   = mk5(100 + 50*(k/5) - 10*(k/5), k % 5, 1'b0);
      a_in_mode  = ((k/5) % 2 == 0);
      chk("t4_in_ready", 128'(a_in_ready), 128'(i < 10));
      if (i >= 5) chk("t4_out_valid", 128'(a_out_valid), 128'(1));
      tick();
      if (acc_flag[0]) k++;
    end
    chk("t4_accepted", 128'(k), 128'(10));
    chk("t4_first_row", 128'(a_out_row), 128'(mk5(100, 0, 1'b1)));

    // Release the output: first matrix drains, input resumes, second matrix drains
    a_out_ready = 1'b1;
    for (int j = 0; j < 11; j++) begin
      if (k < 13) begin
        a_in_valid = 1'b1;
        a_in_row   = mk5(100 + 50*(k/5) - 10*(k/5), k % 5, 1'b0);
        a_in_mode  = ((k/5) % 2 == 0);
      end else begin
        a_in_valid = 1'b0;
      end
      if (j <= 5) chk("t4_in_ready_ret", 128'(a_in_ready), 128'(j >= 5));
      chk("t4_drain_valid", 128'(a_out_valid), 128'(j < 10));
      tick();
      if (acc_flag[0]) k++;
    end
    a_in_valid = 1'b0;

    // Reset with three rows of a matrix partly filled
    chk("t5_partial_rows", 128'(acc_cnt[0]), 128'(3));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5_in_ready", 128'(a_in_ready), 128'(1));
    chk("t5_out_valid", 128'(a_out_valid), 128'(0));
    chk("t5_out_last", 128'(a_out_last), 128'(0));
    run_matrix5("t5", 30, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("t5_no_stale", 128'(a_out_valid), 128'(0));
      tick();
    end

    // Random traffic on N=1 and N=8 with random valid/ready
    for (int i = 0; i < 3000; i++) begin
      if (!b_in_valid || acc_flag[1]) begin
        b_in_valid = ($urandom_range(3) != 0);
        b_in_row   = 8'($urandom);
        b_in_mode  = 1'($urandom_range(1));
      end
      if (!c_in_valid || acc_flag[2]) begin
        c_in_valid = ($urandom_range(3) != 0);
        c_in_row   = {$urandom, $urandom, $urandom, $urandom};
        c_in_mode  = 1'($urandom_range(1));
      end
      b_out_ready = ($urandom_range(3) != 0);
      c_out_ready = ($urandom_range(2) != 0);
      tick();
    end
    b_in_valid = 1'b0;
    c_in_valid = 1'b0;
    b_out_ready = 1'b1;
    c_out_ready = 1'b1;
    for (int i = 0; i < 40; i++) tick();

    chk("a_drained", 128'(exp_wr[0] - exp_rd[0]), 128'(0));
    chk("b_drained", 128'(exp_wr[1] - exp_rd[1]), 128'(0));
    chk("c_drained", 128'(exp_wr[2] - exp_rd[2]), 128'(0));
    chk("b_activity", 128'(out_cnt[1] > 200), 128'(1));
    chk("c_activity", 128'(out_cnt[2] > 100), 128'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
